multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter ALUOP_W, default 4, width of aluop; legal values are 3 or more.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 16, maximum number of wait cycles for mem_ready; 0 disables the timeout.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have ports opcode and func, input, 6 bits each: instruction fields driven from the IR.
REQ-006 SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-007 SHALL have port mem_ready, input, 1 bit: memory access complete.
REQ-008 SHALL have port aluop, output, ALUOP_W bits, with codes ADD=0, SUB=1, AND=2, OR=3, SLT=4, zero-extended.
REQ-009 SHALL have the following 1-bit outputs: alusrc, regdst, regwrite, writemem, readmem, memtoreg, iord, ir_write, pc_write, instr_done, illegal, timeout.
REQ-010 SHALL have port pc_src, output, 2 bits: 0 = PC+4, 1 = branch target, 2 = jump target.
REQ-011 SHALL have port state, output, 3 bits: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.

Function
REQ-012 SHALL support these instructions: R-type (opcode 000000) with func add 100000, sub 100010, and 100100, or 100101, slt 101010; lw 100011; sw 101011; beq 000100; addi 001000; j 000010. Any other opcode/func combination is illegal.
REQ-013 SHALL capture opcode and func into internal registers on the DECODE cycle; EXEC, MEM and WB SHALL use only these captured values.
REQ-014 In FETCH it SHALL drive readmem=1 and iord=0.
- While mem_ready=0: stay in FETCH.
- On mem_ready=1: pulse ir_write=1, pc_write=1, pc_src=0 for that cycle, then go to DECODE.
REQ-015 In DECODE, the next state SHALL be:
- illegal instruction -> TRAP;
- j -> pulse pc_write=1 with pc_src=2 and instr_done=1, then FETCH;
- all other instructions -> EXEC.
REQ-016 In EXEC:
- R-type: aluop from func, alusrc=0, then WB.
- addi: aluop=ADD, alusrc=1, then WB.
- lw/sw: aluop=ADD, alusrc=1, then MEM.
- beq: aluop=SUB, alusrc=0; pc_write=zero (combinational) with pc_src=1; instr_done=1; then FETCH.
REQ-017 In MEM it SHALL drive iord=1, with readmem=1 for lw or writemem=1 for sw, and wait for mem_ready.
- lw: on mem_ready go to WB.
- sw: on mem_ready pulse instr_done=1 and go to FETCH.
REQ-018 In WB it SHALL drive regwrite=1, regdst=1 only for R-type, memtoreg=1 only for lw, and instr_done=1, then go to FETCH.
REQ-019 In TRAP all strobes SHALL be 0 and illegal=1 or timeout=1 SHALL be held (whichever caused entry); TRAP is exited only by reset.
REQ-020 A wait counter SHALL count consecutive FETCH/MEM cycles with mem_ready=0 and clear on state change. When MEM_TIMEOUT>0 and the count reaches MEM_TIMEOUT with mem_ready still 0, the next state SHALL be TRAP with timeout=1.
REQ-021 If mem_ready=1 arrives in the same cycle the count reaches MEM_TIMEOUT, the access SHALL complete normally (mem_ready wins).
REQ-022 Outputs not explicitly asserted in a state SHALL be 0. aluop defaults to ADD. pc_src defaults to 0.
REQ-023 Each instruction SHALL take the following cycles with zero memory wait: j 2, beq 3, R-type/addi 4, sw 4, lw 5.

Reset
REQ-024 While rst_n=0: state=FETCH, captured opcode/func=0, wait counter=0, illegal=0, timeout=0.
REQ-025 While rst_n=0 the outputs SHALL be readmem=1, aluop=0, pc_src=0, and all other outputs 0.
REQ-026 Reset asserted mid-instruction SHALL abort the instruction immediately with no further strobes.
REQ-027 After release, the first active edge SHALL evaluate FETCH.

Verification
REQ-028 add (opcode 0, func 100000), mem_ready=1 always -> states 0,1,2,4; aluop=0 in EXEC; regwrite=1 and regdst=1 in WB; instr_done high in cycle 4 only.
REQ-029 lw, with mem_ready low for 3 cycles in MEM -> MEM held 4 cycles with readmem=1 and iord=1; WB has memtoreg=1 and regdst=0; total 8 cycles.
REQ-030 beq with zero=1, then beq with zero=0 -> pc_write=1 with pc_src=1 in EXEC of the first only; no regwrite in either.
REQ-031 opcode 111111 -> TRAP after DECODE, illegal=1 held; reset pulse returns to FETCH with illegal=0.
REQ-032 MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> TRAP with timeout=1 after 5 FETCH cycles; mem_ready=1 exactly at count 4 completes the fetch instead.
REQ-033 rst_n low during MEM of sw -> writemem drops to 0 asynchronously and state=0.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle CPU control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with a TRAP
// state for illegal instructions and memory wait timeouts.
module multicycle_controller #(
  parameter int ALUOP_W     = 4,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         func,
  input  logic               zero,
  input  logic               mem_ready,
  output logic [ALUOP_W-1:0] aluop,
  output logic               alusrc,
  output logic               regdst,
  output logic               regwrite,
  output logic               writemem,
  output logic               readmem,
  output logic               memtoreg,
  output logic               iord,
  output logic               ir_write,
  output logic               pc_write,
  output logic               instr_done,
  output logic               illegal,
  output logic               timeout,
  output logic [1:0]         pc_src,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(4);

  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  localparam int               CNT_W   = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

  state_t           r_state;
  state_t           w_next_state;
  logic [5:0]       r_opcode;
  logic [5:0]       r_func;
  logic [CNT_W-1:0] r_wait;
  logic             r_illegal;
  logic             r_timeout;
  logic             w_legal;
  logic             w_mem_wait;
  logic             w_wait_expired;

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_RTYPE: is_legal = fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: is_legal = 1'b1;
      default: is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [ALUOP_W-1:0] func_to_aluop(input logic [5:0] fn);
    case (fn)
      FN_SUB:  func_to_aluop = ALU_SUB;
      FN_AND:  func_to_aluop = ALU_AND;
      FN_OR:   func_to_aluop = ALU_OR;
      FN_SLT:  func_to_aluop = ALU_SLT;
      default: func_to_aluop = ALU_ADD;
    endcase
  endfunction

  // Legality is judged on the live IR fields because DECODE is the capture cycle.
  assign w_legal        = is_legal(opcode, func);
  assign w_mem_wait     = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready;
  assign w_wait_expired = (MEM_TIMEOUT > 0) && w_mem_wait && (r_wait == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opcode <= '0;
      r_func   <= '0;
    end else if (r_state == S_DECODE) begin
      r_opcode <= opcode;
      r_func   <= func;
    end
  end

  // Saturates at CNT_MAX so a disabled timeout never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait <= '0;
    end else if (w_next_state != r_state) begin
      r_wait <= '0;
    end else if (w_mem_wait && (r_wait != CNT_MAX)) begin
      r_wait <= r_wait + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if ((r_state == S_DECODE) && !w_legal) r_illegal <= 1'b1;
      if (w_wait_expired)                     r_timeout <= 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    aluop        = ALU_ADD;
    alusrc       = 1'b0;
    regdst       = 1'b0;
    regwrite     = 1'b0;
    writemem     = 1'b0;
    readmem      = 1'b0;
    memtoreg     = 1'b0;
    iord         = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    instr_done   = 1'b0;
    pc_src       = PC_SEQ;

    case (r_state)
      S_FETCH: begin
        readmem = 1'b1;
        if (mem_ready) begin
          ir_write     = 1'b1;
          pc_write     = 1'b1;
          w_next_state = S_DECODE;
        end else if (w_wait_expired) begin
          w_next_state = S_TRAP;
        end
      end

      S_DECODE: begin
        if (!w_legal) begin
          w_next_state = S_TRAP;
        end else if (opcode == OP_J) begin
          pc_write     = 1'b1;
          pc_src       = PC_JUMP;
          instr_done   = 1'b1;
          w_next_state = S_FETCH;
        end else begin
          w_next_state = S_EXEC;
        end
      end

      S_EXEC: begin
        case (r_opcode)
          OP_RTYPE: begin
            aluop        = func_to_aluop(r_func);
            w_next_state = S_WB;
          end
          OP_ADDI: begin
            alusrc       = 1'b1;
            w_next_state = S_WB;
          end
          OP_LW, OP_SW: begin
            alusrc       = 1'b1;
            w_next_state = S_MEM;
          end
          OP_BEQ: begin
            aluop        = ALU_SUB;
            pc_write     = zero;
            pc_src       = PC_BRANCH;
            instr_done   = 1'b1;
            w_next_state = S_FETCH;
          end
          default: w_next_state = S_FETCH;
        endcase
      end

      S_MEM: begin
        iord = 1'b1;
        if (r_opcode == OP_LW) readmem  = 1'b1;
        else                   writemem = 1'b1;
        if (mem_ready) begin
          if (r_opcode == OP_LW) begin
            w_next_state = S_WB;
          end else begin
            instr_done   = 1'b1;
            w_next_state = S_FETCH;
          end
        end else if (w_wait_expired) begin
          w_next_state = S_TRAP;
        end
      end

      S_WB: begin
        regwrite     = 1'b1;
        regdst       = (r_opcode == OP_RTYPE);
        memtoreg     = (r_opcode == OP_LW);
        instr_done   = 1'b1;
        w_next_state = S_FETCH;
      end

      S_TRAP: w_next_state = S_TRAP;

      default: w_next_state = S_FETCH;
    endcase

    // Reset parks the FSM in FETCH; suppress the fetch-complete strobes meanwhile.
    if (!rst_n) begin
      ir_write = 1'b0;
      pc_write = 1'b0;
    end
  end

  assign illegal = r_illegal;
  assign timeout = r_timeout;
  assign state   = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-cycle expected output words are queued
// with their stimulus and compared on the falling edge.
`timescale 1ns/1ps
module tb_multicycle_controller;

  localparam int TMO = 4;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [5:0] FN_TAB  [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  localparam logic [3:0] AOP_TAB [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};

  // Flag bit order: alusrc regdst regwrite writemem readmem memtoreg iord ir_write pc_write instr_done illegal timeout
  localparam logic [11:0] B_ALUSRC = 12'h800;
  localparam logic [11:0] B_REGDST = 12'h400;
  localparam logic [11:0] B_REGWR  = 12'h200;
  localparam logic [11:0] B_WMEM   = 12'h100;
  localparam logic [11:0] B_RMEM   = 12'h080;
  localparam logic [11:0] B_M2R    = 12'h040;
  localparam logic [11:0] B_IORD   = 12'h020;
  localparam logic [11:0] B_IRW    = 12'h010;
  localparam logic [11:0] B_PCW    = 12'h008;
  localparam logic [11:0] B_DONE   = 12'h004;
  localparam logic [11:0] B_ILL    = 12'h002;
  localparam logic [11:0] B_TMO    = 12'h001;

  // Word layout: {state[2:0], aluop[3:0], pc_src[1:0], flags[11:0]}
  localparam logic [20:0] E_FW       = {3'd0, 4'd0, 2'd0, B_RMEM};
  localparam logic [20:0] E_FG       = {3'd0, 4'd0, 2'd0, B_RMEM | B_IRW | B_PCW};
  localparam logic [20:0] E_DEC      = {3'd1, 4'd0, 2'd0, 12'h000};
  localparam logic [20:0] E_DEC_J    = {3'd1, 4'd0, 2'd2, B_PCW | B_DONE};
  localparam logic [20:0] E_EX_IMM   = {3'd2, 4'd0, 2'd0, B_ALUSRC};
  localparam logic [20:0] E_MEM_LW   = {3'd3, 4'd0, 2'd0, B_RMEM | B_IORD};
  localparam logic [20:0] E_MEM_SW   = {3'd3, 4'd0, 2'd0, B_WMEM | B_IORD};
  localparam logic [20:0] E_WB_R     = {3'd4, 4'd0, 2'd0, B_REGWR | B_REGDST | B_DONE};
  localparam logic [20:0] E_WB_I     = {3'd4, 4'd0, 2'd0, B_REGWR | B_DONE};
  localparam logic [20:0] E_WB_LW    = {3'd4, 4'd0, 2'd0, B_REGWR | B_M2R | B_DONE};
  localparam logic [20:0] E_TRAP_ILL = {3'd5, 4'd0, 2'd0, B_ILL};
  localparam logic [20:0] E_TRAP_TMO = {3'd5, 4'd0, 2'd0, B_TMO};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] func = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [3:0] aluop;
  logic       alusrc, regdst, regwrite, writemem, readmem, memtoreg;
  logic       iord, ir_write, pc_write, instr_done, illegal, timeout;
  logic [1:0] pc_src;
  logic [2:0] state;
  logic [20:0] obs;

  logic [13:0] stim_q [$];
  logic [20:0] exp_q  [$];
  int tests = 0;
  int fails = 0;

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  multicycle_controller #(
    .ALUOP_W(4),
    .MEM_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .zero(zero),
    .mem_ready(mem_ready), .aluop(aluop), .alusrc(alusrc), .regdst(regdst),
    .regwrite(regwrite), .writemem(writemem), .readmem(readmem),
    .memtoreg(memtoreg), .iord(iord), .ir_write(ir_write), .pc_write(pc_write),
    .instr_done(instr_done), .illegal(illegal), .timeout(timeout),
    .pc_src(pc_src), .state(state)
  );

  assign obs = {state, aluop, pc_src, alusrc, regdst, regwrite, writemem, readmem,
                memtoreg, iord, ir_write, pc_write, instr_done, illegal, timeout};

  // Driver helpers (stimulus only)
  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] r6();
    return 6'($urandom_range(0, 63));
  endfunction

  task automatic push_cyc(input logic [5:0] op, input logic [5:0] fn, input logic mr,
                          input logic z, input logic [20:0] e);
    stim_q.push_back({op, fn, mr, z});
    exp_q.push_back(e);
  endtask

  // kind: 0 R-type (sel picks func), 1 addi, 2 lw, 3 sw, 4 beq, 5 j
  task automatic push_instr(input int kind, input int sel, input int fw, input int mw, input logic z);
    logic [5:0] op;
    logic [5:0] fn;
    fn = r6();
    case (kind)
      0:       begin op = OP_R; fn = FN_TAB[sel]; end
      1:       op = OP_ADDI;
      2:       op = OP_LW;
      3:       op = OP_SW;
      4:       op = OP_BEQ;
      default: op = OP_J;
    endcase
    for (int i = 0; i < fw; i++) push_cyc(op, fn, 1'b0, rbit(), E_FW);
    push_cyc(op, fn, 1'b1, rbit(), E_FG);
    push_cyc(op, fn, rbit(), rbit(), (kind == 5) ? E_DEC_J : E_DEC);
    case (kind)
      0: begin
        push_cyc(r6(), r6(), rbit(), rbit(), {3'd2, AOP_TAB[sel], 2'd0, 12'h000});
        push_cyc(r6(), r6(), rbit(), rbit(), E_WB_R);
      end
      1: begin
        push_cyc(r6(), r6(), rbit(), rbit(), E_EX_IMM);
        push_cyc(r6(), r6(), rbit(), rbit(), E_WB_I);
      end
      2: begin
        push_cyc(r6(), r6(), rbit(), rbit(), E_EX_IMM);
        for (int i = 0; i < mw; i++) push_cyc(r6(), r6(), 1'b0, rbit(), E_MEM_LW);
        push_cyc(r6(), r6(), 1'b1, rbit(), E_MEM_LW);
        push_cyc(r6(), r6(), rbit(), rbit(), E_WB_LW);
      end
      3: begin
        push_cyc(r6(), r6(), rbit(), rbit(), E_EX_IMM);
        for (int i = 0; i < mw; i++) push_cyc(r6(), r6(), 1'b0, rbit(), E_MEM_SW);
        push_cyc(r6(), r6(), 1'b1, rbit(), E_MEM_SW | 21'(B_DONE));
      end
      4: push_cyc(r6(), r6(), rbit(), z, {3'd2, 4'd1, 2'd1, z ? (B_PCW | B_DONE) : B_DONE});
      default: ;
    endcase
  endtask

  // Tests
  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; opcode = r6(); func = r6(); zero = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if (obs !== E_FW) begin
      fails++; $display("FAIL reset_outputs: got %h expected %h", obs, E_FW);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_rtype();
    logic [13:0] s;
    logic [20:0] e;
    int n = 0;
    for (int k = 0; k < 5; k++) push_instr(0, k, 0, 0, 1'b0);
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      {opcode, func, mem_ready, zero} = s;
      @(negedge clk);
      tests++;
      if (obs !== e) begin fails++; $display("FAIL rtype[%0d]: got %h expected %h", n, obs, e); end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_addi_j();
    logic [13:0] s;
    logic [20:0] e;
    int n = 0;
    push_instr(1, 0, 0, 0, 1'b0);
    push_instr(5, 0, 0, 0, 1'b0);
    push_instr(5, 0, 1, 0, 1'b0);
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      {opcode, func, mem_ready, zero} = s;
      @(negedge clk);
      tests++;
      if (obs !== e) begin fails++; $display("FAIL addi_j[%0d]: got %h expected %h", n, obs, e); end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw_wait();
    logic [13:0] s;
    logic [20:0] e;
    int n = 0;
    push_instr(2, 0, 0, 3, 1'b0);
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      {opcode, func, mem_ready, zero} = s;
      @(negedge clk);
      tests++;
      if (obs !== e) begin fails++; $display("FAIL lw_wait[%0d]: got %h expected %h", n, obs, e); end
      n++;
      @(posedge clk); #1;
    end
    tests++;
    if (n !== 8) begin fails++; $display("FAIL lw_cycles: got %0d expected 8", n); end
  endtask

  task automatic test_sw_wait();
    logic [13:0] s;
    logic [20:0] e;
    int n = 0;
    push_instr(3, 0, 3, 3, 1'b0);
    push_instr(3, 0, 0, 0, 1'b0);
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      {opcode, func, mem_ready, zero} = s;
      @(negedge clk);
      tests++;
      if (obs !== e) begin fails++; $display("FAIL sw_wait[%0d]: got %h expected %h", n, obs, e); end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_beq();
    logic [13:0] s;
    logic [20:0] e;
    int n = 0;
    push_instr(4, 0, 0, 0, 1'b1);
    push_instr(4, 0, 0, 0, 1'b0);
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      {opcode, func, mem_ready, zero} = s;
      @(negedge clk);
      tests++;
      if (obs !== e) begin fails++; $display("FAIL beq[%0d]: got %h expected %h", n, obs, e); end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout_edge();
    logic [13:0] s;
    logic [20:0] e;
    int n = 0;
    push_instr(0, 0, TMO, 0, 1'b0);
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      {opcode, func, mem_ready, zero} = s;
      @(negedge clk);
      tests++;
      if (obs !== e) begin fails++; $display("FAIL timeout_edge[%0d]: got %h expected %h", n, obs, e); end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout_trap();
    logic [13:0] s;
    logic [20:0] e;
    int n = 0;
    for (int i = 0; i <= TMO; i++) push_cyc(r6(), r6(), 1'b0, rbit(), E_FW);
    for (int i = 0; i < 3; i++) push_cyc(r6(), r6(), rbit(), rbit(), E_TRAP_TMO);
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      {opcode, func, mem_ready, zero} = s;
      @(negedge clk);
      tests++;
      if (obs !== e) begin fails++; $display("FAIL timeout_trap[%0d]: got %h expected %h", n, obs, e); end
      n++;
      @(posedge clk); #1;
    end
    rst_n = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (obs !== E_FW) begin fails++; $display("FAIL timeout_reset: got %h expected %h", obs, E_FW); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_illegal();
    logic [13:0] s;
    logic [20:0] e;
    logic [5:0]  ops [2];
    logic [5:0]  fns [2];
    int n;
    ops[0] = 6'b111111; fns[0] = r6();
    ops[1] = OP_R;      fns[1] = 6'b000001;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      push_cyc(ops[k], fns[k], 1'b1, rbit(), E_FG);
      push_cyc(ops[k], fns[k], rbit(), rbit(), E_DEC);
      for (int i = 0; i < 3; i++) push_cyc(r6(), r6(), rbit(), rbit(), E_TRAP_ILL);
      while (exp_q.size() != 0) begin
        s = stim_q.pop_front(); e = exp_q.pop_front();
        {opcode, func, mem_ready, zero} = s;
        @(negedge clk);
        tests++;
        if (obs !== e) begin fails++; $display("FAIL illegal%0d[%0d]: got %h expected %h", k, n, obs, e); end
        n++;
        @(posedge clk); #1;
      end
      rst_n = 1'b0; mem_ready = 1'b1;
      @(negedge clk);
      tests++;
      if (obs !== E_FW) begin fails++; $display("FAIL illegal%0d_reset: got %h expected %h", k, obs, E_FW); end
      @(posedge clk); #1;
      rst_n = 1'b1;
    end
  endtask

  task automatic test_reset_mid_sw();
    logic [13:0] s;
    logic [20:0] e;
    logic [5:0]  fn;
    int n = 0;
    fn = r6();
    push_cyc(OP_SW, fn, 1'b1, rbit(), E_FG);
    push_cyc(OP_SW, fn, rbit(), rbit(), E_DEC);
    push_cyc(r6(), r6(), rbit(), rbit(), E_EX_IMM);
    push_cyc(r6(), r6(), 1'b0, rbit(), E_MEM_SW);
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      {opcode, func, mem_ready, zero} = s;
      @(negedge clk);
      tests++;
      if (obs !== e) begin fails++; $display("FAIL mid_sw[%0d]: got %h expected %h", n, obs, e); end
      n++;
      @(posedge clk); #1;
    end
    #1;
    tests++;
    if (obs !== E_MEM_SW) begin fails++; $display("FAIL mid_sw_hold: got %h expected %h", obs, E_MEM_SW); end
    rst_n = 1'b0;
    #1;
    tests++;
    if (obs !== E_FW) begin fails++; $display("FAIL mid_sw_async_reset: got %h expected %h", obs, E_FW); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [13:0] s;
    logic [20:0] e;
    int n = 0;
    for (int k = 0; k < 12; k++)
      push_instr($urandom_range(0, 5), $urandom_range(0, 4), $urandom_range(0, 3),
                 $urandom_range(0, 3), rbit());
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      {opcode, func, mem_ready, zero} = s;
      @(negedge clk);
      tests++;
      if (obs !== e) begin fails++; $display("FAIL back_to_back[%0d]: got %h expected %h", n, obs, e); end
      n++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_addi_j();
    test_lw_wait();
    test_sw_wait();
    test_beq();
    test_timeout_edge();
    test_timeout_trap();
    test_reset_mid_sw();
    test_illegal();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
